// File: rtl/ex_matrix_unit_if.sv
// ex_matrix_unit_if: ID/EX operand, pipeline-control and EX/MEM result bundle for the matrix unit
interface ex_matrix_unit_if;
  logic         i_start;
  logic         i_flush;
  logic [2:0]   i_func3;
  logic         i_func7;
  logic [127:0] i_matrix_a;
  logic [31:0]  i_vec_x;
  logic [31:0]  i_bias;
  logic [4:0]   i_rd_in;
  logic         o_stall;
  logic         o_done;
  logic [31:0]  o_result;
  logic [4:0]   o_rd_out;
  logic [31:0]  o_perf_ops;
  logic [31:0]  o_perf_cycles;
  modport master (
    output i_start, i_flush, i_func3, i_func7, i_matrix_a, i_vec_x, i_bias, i_rd_in,
    input  o_stall, o_done, o_result, o_rd_out, o_perf_ops, o_perf_cycles
  );
  modport slave (
    input  i_start, i_flush, i_func3, i_func7, i_matrix_a, i_vec_x, i_bias, i_rd_in,
    output o_stall, o_done, o_result, o_rd_out, o_perf_ops, o_perf_cycles
  );
endinterface

// File: rtl/ex_matrix_unit.sv
// ex_matrix_unit: iterative 4x4 int8 matrix-vector engine, one row per cycle, stalls the front end while busy
// Optional op/busy-cycle counters are built only when MATRIX_UNIT_PERF_EN is defined.
module ex_matrix_unit #(
  parameter int ROWS = 4,
  parameter int EW   = 8,
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst,
  ex_matrix_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROW  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]               r_state;
  logic [1:0]               r_row_cnt;
  logic [ROWS*ROWS*EW-1:0]  r_a;
  logic [ROWS*EW-1:0]       r_x;
  logic [XLEN-1:0]          r_bias;
  logic                     r_red;
  logic                     r_sgn;
  logic [4:0]               r_rd;
  logic [3*EW-1:0]          r_sat;
  logic [19:0]              r_acc;
  logic [XLEN-1:0]          r_result;
  logic [4:0]               r_rd_out;
  logic [2*EW-1:0]          w_p [ROWS];
  logic [17:0]              w_sum;
  logic [EW-1:0]            w_lane;
  logic [19:0]              w_acc;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_stall;
  logic                     w_done;
  assign w_accept = (r_state == S_IDLE) && bus.i_start && !bus.i_flush;
  assign w_last   = r_row_cnt == 2'(ROWS - 1);
  assign w_stall  = w_accept || ((r_state == S_ROW) && !bus.i_flush);
  assign w_done   = r_state == S_DONE;
  // Products are formed on 16b operands extended per func7; the low 16 bits are exact for both signednesses.
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < ROWS; j++) begin
      w_p[j] = {{EW{r_sgn & r_a[(int'(r_row_cnt)*ROWS+j)*EW+EW-1]}}, r_a[(int'(r_row_cnt)*ROWS+j)*EW +: EW]}
             * {{EW{r_sgn & r_x[j*EW+EW-1]}}, r_x[j*EW +: EW]};
      w_sum  = w_sum + {{2{r_sgn & w_p[j][2*EW-1]}}, w_p[j]};
    end
  end
  assign w_lane = r_sgn ? (($signed(w_sum) > 18'sd127) ? 8'h7F : ($signed(w_sum) < -18'sd128) ? 8'h80 : w_sum[EW-1:0])
                        : ((w_sum > 18'd255) ? 8'hFF : w_sum[EW-1:0]);
  assign w_acc  = r_acc + {{2{r_sgn & w_sum[17]}}, w_sum};
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_row_cnt <= '0;
      r_result  <= '0;
      r_rd_out  <= '0;
    end else begin
      r_state   <= w_accept ? S_ROW
                 : ((r_state == S_ROW) && !bus.i_flush) ? (w_last ? S_DONE : S_ROW)
                 : S_IDLE;
      r_row_cnt <= (r_state == S_ROW) ? r_row_cnt + 2'd1 : 2'd0;
      if ((r_state == S_ROW) && w_last && !bus.i_flush) begin
        r_result <= r_red ? r_bias + {{(XLEN-20){r_sgn & w_acc[19]}}, w_acc} : {w_lane, r_sat};
        r_rd_out <= r_rd;
      end
    end
  end
  // Operand capture and per-row accumulation; lanes 0..2 shift in so row 3 lands on top at completion.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a    <= bus.i_matrix_a;
      r_x    <= bus.i_vec_x;
      r_bias <= bus.i_bias;
      r_red  <= bus.i_func3 == 3'b001;
      r_sgn  <= bus.i_func7;
      r_rd   <= bus.i_rd_in;
      r_acc  <= '0;
    end else if (r_state == S_ROW) begin
      r_acc  <= w_acc;
      r_sat  <= {w_lane, r_sat[3*EW-1:EW]};
    end
  end
  assign bus.o_stall  = w_stall;
  assign bus.o_done   = w_done;
  assign bus.o_result = r_result;
  assign bus.o_rd_out = r_rd_out;
`ifdef MATRIX_UNIT_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_cycles;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_ops    <= '0;
      r_perf_cycles <= '0;
    end else begin
      r_perf_ops    <= r_perf_ops + {31'd0, w_done};
      r_perf_cycles <= r_perf_cycles + {31'd0, w_stall};
    end
  end
  assign bus.o_perf_ops    = r_perf_ops;
  assign bus.o_perf_cycles = r_perf_cycles;
`else
  assign bus.o_perf_ops    = '0;
  assign bus.o_perf_cycles = '0;
`endif
endmodule
